// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the byte-addressed data memory: access-size codes,
// controller states, lane byte-enable generation and read-data extraction.
package dmem_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Little-endian byte enables for an aligned access of the given size.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Pick the addressed byte/half out of a word and zero- or sign-extend it.
  function automatic logic [31:0] read_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{sgn & b[7]}}, b};
      SZ_HALF: res = {{16{sgn & h[15]}}, h};
      SZ_WORD: res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_bus_array.sv
// DEPTH x 32 storage with per-byte write enables and an asynchronous read port.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] r_mem [DEPTH];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_be[k]) begin
        r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_bus.sv
// Data-memory front end: valid/ready request port, alignment checking,
// configurable read latency, post-reset zero sweep and registered response.
module dmem_bus
  import dmem_bus_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W+1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [2:0]        r_cnt;
  logic [ADDR_W+1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_err;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_req_err;
  logic [3:0]        w_arr_be;
  logic [ADDR_W-1:0] w_arr_waddr;
  logic [31:0]       w_arr_wdata;
  logic [ADDR_W-1:0] w_arr_raddr;
  logic [31:0]       w_arr_rdata;

  // Requests are only taken in IDLE and never while reset is asserted.
  assign w_accept = i_req_valid && i_rst_n && (r_state == IDLE);

  assign w_req_err = (i_req_size == SZ_ILL) ||
                     ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
                     ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));

  // While waiting out the read latency the latched address drives the array.
  assign w_arr_raddr = (r_state == WAIT) ? r_addr[ADDR_W+1:2] : i_req_addr[ADDR_W+1:2];

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_idx == ADDR_W'(DEPTH - 1)) w_state_next = IDLE;
      IDLE:    if (w_accept && !i_req_we && (RD_LAT != 0)) w_state_next = WAIT;
      WAIT:    if (r_cnt == 3'd1) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State-derived outputs and array write port steering.
  always_comb begin
    o_req_ready = i_rst_n && (r_state == IDLE);
    o_busy      = (r_state == CLEAR);
    w_arr_be    = 4'b0000;
    w_arr_waddr = i_req_addr[ADDR_W+1:2];
    case (i_req_size)
      SZ_BYTE: w_arr_wdata = {4{i_req_wdata[7:0]}};
      SZ_HALF: w_arr_wdata = {2{i_req_wdata[15:0]}};
      default: w_arr_wdata = i_req_wdata;
    endcase
    if (r_state == CLEAR) begin
      w_arr_be    = 4'b1111;
      w_arr_waddr = r_idx;
      w_arr_wdata = 32'd0;
    end else if (w_accept && i_req_we && !w_req_err) begin
      w_arr_be = lane_be(i_req_size, i_req_addr[1:0]);
    end
    if (!i_rst_n) begin
      w_arr_be = 4'b0000;
    end
  end

  // Sweep index, latency counter and request attributes latched at accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx    <= '0;
      r_cnt    <= 3'd0;
      r_addr   <= '0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == CLEAR) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
      if (w_accept) begin
        r_addr   <= i_req_addr;
        r_size   <= i_req_size;
        r_signed <= i_req_signed;
        r_err    <= w_req_err;
        r_cnt    <= 3'(RD_LAT);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // One-cycle response pulse; data and error are forced to zero otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      if (w_accept && (i_req_we || (RD_LAT == 0))) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_req_err;
        if (!i_req_we && !w_req_err) begin
          r_rsp_rdata <= read_extract(w_arr_rdata, i_req_size, i_req_addr[1:0], i_req_signed);
        end
      end else if ((r_state == WAIT) && (r_cnt == 3'd1)) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= r_err;
        if (!r_err) begin
          r_rsp_rdata <= read_extract(w_arr_rdata, r_size, r_addr[1:0], r_signed);
        end
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .i_clk   (i_clk),
    .i_be    (w_arr_be),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_raddr (w_arr_raddr),
    .o_rdata (w_arr_rdata)
  );

endmodule

// File: tb/tb_dmem_bus.sv
// Bench for dmem_bus: two instances (zero-fill, no latency / no fill, 2-cycle
// latency), each shadowed by a transaction-level model and checked every cycle,
// plus directed requests with literal expected results.
module tb_dmem_bus;
  import dmem_bus_pkg::*;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, valid, we, sgn, ready, rvalid, err, busy;
  logic [1:0][1:0]  size;
  logic [1:0][11:0] addr;
  logic [1:0][31:0] wdata, rdata;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int AW    = (gi == 0) ? 10 : 6;
    localparam int LAT   = (gi == 0) ? 0 : 2;
    localparam int COR   = (gi == 0) ? 1 : 0;
    localparam int DEPTH = 1 << AW;

    dmem_bus #(.ADDR_W(AW), .RD_LAT(LAT), .CLEAR_ON_RESET(COR)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n[gi]),
      .i_req_valid  (valid[gi]),
      .o_req_ready  (ready[gi]),
      .i_req_we     (we[gi]),
      .i_req_size   (size[gi]),
      .i_req_signed (sgn[gi]),
      .i_req_addr   (addr[gi][AW+1:0]),
      .i_req_wdata  (wdata[gi]),
      .o_rsp_valid  (rvalid[gi]),
      .o_rsp_rdata  (rdata[gi]),
      .o_rsp_err    (err[gi]),
      .o_busy       (busy[gi])
    );

    logic [31:0] mem [DEPTH];
    rsp_t        q[$];
    int          edge_n     = 0;
    int          clear_done = 0;
    int          wait_done  = 0;
    bit          started    = 0;

    // Transaction model: edge_n counts rising edges; entries carry the edge
    // after which the response must be visible.
    always @(posedge clk) begin : model
      rsp_t        r;
      int          wi;
      logic [1:0]  ln;
      logic [1:0]  sz;
      logic        bad;
      logic [7:0]  b;
      logic [15:0] h;
      bit          rdy;
      rdy = started && rst_n[gi] && (edge_n >= clear_done) && (edge_n >= wait_done);
      edge_n++;
      if (!rst_n[gi]) begin
        started = 1;
        q.delete();
        wait_done  = edge_n;
        clear_done = (COR != 0) ? edge_n + DEPTH : edge_n;
        if (COR != 0) begin
          for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
        end
      end else if (rdy && valid[gi]) begin
        wi  = int'(addr[gi][AW+1:2]);
        ln  = addr[gi][1:0];
        sz  = size[gi];
        bad = (sz == 2'b11) || (sz == 2'b01 && ln[0]) || (sz == 2'b10 && ln != 2'b00);
        r.due = we[gi] ? edge_n : edge_n + LAT;
        r.e   = bad;
        r.d   = 32'd0;
        if (!bad && we[gi]) begin
          case (sz)
            2'b00:   mem[wi][8*ln +: 8] = wdata[gi][7:0];
            2'b01:   mem[wi][16*ln[1] +: 16] = wdata[gi][15:0];
            default: mem[wi] = wdata[gi];
          endcase
        end else if (!bad) begin
          b = mem[wi][8*ln +: 8];
          h = mem[wi][16*ln[1] +: 16];
          case (sz)
            2'b00:   r.d = sgn[gi] ? 32'(signed'(b)) : 32'(b);
            2'b01:   r.d = sgn[gi] ? 32'(signed'(h)) : 32'(h);
            default: r.d = mem[wi];
          endcase
        end
        if (!we[gi]) wait_done = edge_n + LAT;
        q.push_back(r);
      end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
      logic        ev, ee, er, eb;
      logic [31:0] ed;
      if (started) begin
        ev = 1'b0; ee = 1'b0; ed = 32'd0;
        if (q.size() > 0 && q[0].due == edge_n) begin
          ev = 1'b1; ed = q[0].d; ee = q[0].e;
          void'(q.pop_front());
        end
        er = rst_n[gi] && (edge_n >= clear_done) && (edge_n >= wait_done);
        eb = (COR != 0) && (edge_n < clear_done);
        chk($sformatf("dut%0d rsp_valid e%0d", gi, edge_n), 32'(rvalid[gi]), 32'(ev));
        chk($sformatf("dut%0d rsp_rdata e%0d", gi, edge_n), rdata[gi], ed);
        chk($sformatf("dut%0d rsp_err e%0d", gi, edge_n), 32'(err[gi]), 32'(ee));
        chk($sformatf("dut%0d req_ready e%0d", gi, edge_n), 32'(ready[gi]), 32'(er));
        chk($sformatf("dut%0d busy e%0d", gi, edge_n), 32'(busy[gi]), 32'(eb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for its response pulse.
  task automatic do_req(input int id, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [11:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    bit acc;
    bit got;
    acc = 0; got = 0; rd = 32'd0; er = 1'b0;
    we[id] = w; size[id] = sz; sgn[id] = sg; addr[id] = a; wdata[id] = wd; valid[id] = 1'b1;
    for (int n = 0; n < 3000 && !acc; n++) begin
      acc = ready[id];
      tick();
    end
    valid[id] = 1'b0;
    if (!acc) begin
      n_assert++; n_fail++;
      $display("FAIL accept timeout dut%0d addr 0x%03h", id, a);
    end
    for (int n = 0; n < 20 && acc && !got; n++) begin
      if (rvalid[id]) begin
        got = 1; rd = rdata[id]; er = err[id];
      end else begin
        tick();
      end
    end
    if (acc && !got) begin
      n_assert++; n_fail++;
      $display("FAIL response timeout dut%0d addr 0x%03h", id, a);
    end
    $display("dut%0d %s size=%0d signed=%0d addr=0x%03h wdata=0x%08h -> rdata=0x%08h err=%0d",
             id, w ? "WR" : "RD", sz, sg, a, wd, rd, er);
  endtask

  task automatic expect_req(input string nm, input int id, input logic w, input logic [1:0] sz,
                            input logic sg, input logic [11:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    do_req(id, w, sz, sg, a, wd, rd, er);
    chk({nm, " rdata"}, rd, exp_d);
    chk({nm, " err"}, 32'(er), 32'(exp_e));
  endtask

  task automatic rand_phase(input int id, input int cycles, input bit with_rst);
    for (int c = 0; c < cycles; c++) begin
      valid[id] = ($urandom_range(0, 2) != 0);
      we[id]    = 1'($urandom_range(0, 1));
      size[id]  = 2'($urandom_range(0, 3));
      sgn[id]   = 1'($urandom_range(0, 1));
      addr[id]  = (id == 0) ? 12'($urandom_range(0, 63)) : 12'($urandom_range(0, 255));
      wdata[id] = $urandom;
      if (with_rst) rst_n[id] = ($urandom_range(0, 39) != 0);
      tick();
    end
    valid[id] = 1'b0;
    rst_n[id] = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cnt;
    rst_n = 2'b00; valid = 2'b00; we = 2'b00; sgn = 2'b00;
    size = '0; addr = '0; wdata = '0;
    repeat (3) tick();
    rst_n = 2'b11;

    // Zero sweep interrupted by a reset, then timed from the last reset edge.
    repeat (100) tick();
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    cnt = 0;
    for (int n = 0; n < 3000 && busy[0]; n++) begin
      cnt++;
      tick();
    end
    chk("clear busy cycles", 32'(cnt), 32'd1024);
    chk("ready after clear", 32'(ready[0]), 32'd1);

    expect_req("lw 3FC after clear", 0, 0, SZ_WORD, 0, 12'h3FC, 0, 32'h0000_0000, 0);
    expect_req("sw 010", 0, 1, SZ_WORD, 0, 12'h010, 32'h1234_5678, 32'h0, 0);
    expect_req("lbu 013", 0, 0, SZ_BYTE, 0, 12'h013, 0, 32'h0000_0012, 0);
    expect_req("lhu 012", 0, 0, SZ_HALF, 0, 12'h012, 0, 32'h0000_1234, 0);
    expect_req("lw 010", 0, 0, SZ_WORD, 0, 12'h010, 0, 32'h1234_5678, 0);
    expect_req("sb 021", 0, 1, SZ_BYTE, 0, 12'h021, 32'h0000_0080, 32'h0, 0);
    expect_req("lw 020", 0, 0, SZ_WORD, 0, 12'h020, 0, 32'h0000_8000, 0);
    expect_req("lb 021", 0, 0, SZ_BYTE, 1, 12'h021, 0, 32'hFFFF_FF80, 0);
    expect_req("lbu 021", 0, 0, SZ_BYTE, 0, 12'h021, 0, 32'h0000_0080, 0);
    expect_req("lh 020", 0, 0, SZ_HALF, 1, 12'h020, 0, 32'hFFFF_8000, 0);
    expect_req("sh 031 misaligned", 0, 1, SZ_HALF, 0, 12'h031, 32'h0000_BEEF, 32'h0, 1);
    expect_req("lw 030 unchanged", 0, 0, SZ_WORD, 0, 12'h030, 0, 32'h0000_0000, 0);
    expect_req("size 11 read", 0, 0, SZ_ILL, 0, 12'h010, 0, 32'h0000_0000, 1);
    expect_req("lw 012 misaligned", 0, 0, SZ_WORD, 0, 12'h012, 0, 32'h0000_0000, 1);
    rand_phase(0, 600, 0);

    // Second instance: give every word a known value first.
    for (int i = 0; i < 64; i++) do_req(1, 1, SZ_WORD, 0, 12'(i * 4), $urandom, rd, er);
    expect_req("lat sw 008", 1, 1, SZ_WORD, 0, 12'h008, 32'hCAFE_F00D, 32'h0, 0);

    // Read latency 2: accepted at T, response only in cycle T+3.
    we[1] = 1'b0; size[1] = SZ_WORD; sgn[1] = 1'b0; addr[1] = 12'h008; valid[1] = 1'b1;
    chk("lat ready at T", 32'(ready[1]), 32'd1);
    tick();
    valid[1] = 1'b0;
    chk("lat ready T+1", 32'(ready[1]), 32'd0);
    chk("lat rsp_valid T+1", 32'(rvalid[1]), 32'd0);
    tick();
    chk("lat ready T+2", 32'(ready[1]), 32'd0);
    chk("lat rsp_valid T+2", 32'(rvalid[1]), 32'd0);
    tick();
    chk("lat rsp_valid T+3", 32'(rvalid[1]), 32'd1);
    chk("lat rdata T+3", rdata[1], 32'hCAFE_F00D);
    chk("lat ready T+3", 32'(ready[1]), 32'd1);
    $display("dut1 RD lat addr=0x008 -> rdata=0x%08h", rdata[1]);

    // Same read with reset in cycle T+1: the response must be dropped.
    valid[1] = 1'b1;
    tick();
    valid[1] = 1'b0;
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      chk("dropped read rsp_valid", 32'(rvalid[1]), 32'd0);
      tick();
    end
    expect_req("lw 008 after reset", 1, 0, SZ_WORD, 0, 12'h008, 0, 32'hCAFE_F00D, 0);
    expect_req("lat lh 00A", 1, 0, SZ_HALF, 1, 12'h00A, 0, 32'hFFFF_CAFE, 0);
    rand_phase(1, 800, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
